axis_data_unpack: RTL and testbench

Receive-side counterpart of the C2H frame packer. Accepts host-to-card AXI-Stream frames from the XDMA H2C channel, strips the 8-bit frame sequence number from the first beat, reassembles the `DATA_WIDTH`-bit payload and presents it to the core through a one-entry valid/ready output register. Sequence gaps and framing errors are detected and counted so that host-side replay or stimulus injection can be checked on the FPGA.

---
 rtl/axis_frame_pkg.sv | 17 +
 rtl/axis_data_unpack.sv | 162 ++++++++++++++++
 tb/tb_axis_data_unpack.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_pkg.sv
// Frame format shared by the C2H packer and H2C unpacker: state encoding,
// sequence-number width and the beats-per-frame calculation.
package axis_frame_pkg;

    localparam int SEQ_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_DROP = 2'd1,
        ST_FULL = 2'd2
    } ustate_t;

    function automatic int num_beats(input int data_width, input int axis_width);
        return (data_width + SEQ_WIDTH + axis_width - 1) / axis_width;
    endfunction

endpackage

// File: rtl/axis_data_unpack.sv
// Reassembles H2C AXI-Stream frames into one DATA_WIDTH payload held in a one-entry output register.
// Checks the frame sequence number and tlast placement; counts errors.
module axis_data_unpack
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                       s_axis_h2c_aclk,
    input  logic                       s_axis_h2c_areset,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_h2c_tdata,
    input  logic [63:0]                s_axis_h2c_tkeep,
    input  logic                       s_axis_h2c_tlast,
    input  logic                       s_axis_h2c_tvalid,
    output logic                       s_axis_h2c_tready,
    output logic [DATA_WIDTH-1:0]      data,
    output logic [SEQ_WIDTH-1:0]       data_seq,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       seq_err,
    output logic                       frame_err,
    output logic [15:0]                err_cnt,
    output logic [1:0]                 ustate
);

    localparam int NUM_BEATS = num_beats(DATA_WIDTH, AXIS_DATA_WIDTH);
    localparam int ASM_W     = NUM_BEATS * AXIS_DATA_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    ustate_t                r_state;
    ustate_t                w_state_nxt;
    logic                   r_live;
    logic [ASM_W-1:0]       r_asm;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [SEQ_WIDTH-1:0]   r_data_seq;
    logic                   r_data_valid;
    logic                   r_seq_err;
    logic                   r_frame_err;
    logic [15:0]            r_err_cnt;
    logic [SEQ_WIDTH-1:0]   r_exp_seq;

    logic                   w_tready;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_early;
    logic                   w_missing;
    logic                   w_seq_mis;
    logic                   w_err_evt;
    logic [ASM_W-1:0]       w_asm_nxt;
    logic [SEQ_WIDTH-1:0]   w_seq_in;
    logic                   w_unused;

    // r_live keeps tready low while reset is held and releases it on the first edge after.
    assign w_tready  = r_live && (r_state != ST_FULL);
    assign w_accept  = s_axis_h2c_tvalid && w_tready;
    assign w_asm_nxt = {s_axis_h2c_tdata, r_asm[ASM_W-1:AXIS_DATA_WIDTH]};
    assign w_seq_in  = w_asm_nxt[SEQ_WIDTH-1:0];
    assign w_seq_mis = w_done && (w_seq_in != r_exp_seq);
    assign w_err_evt = w_seq_mis || w_early || w_missing;
    assign w_unused  = ^{s_axis_h2c_tkeep, w_asm_nxt[ASM_W-1:DATA_WIDTH+SEQ_WIDTH],
                         r_asm[AXIS_DATA_WIDTH-1:0]};

    always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
        if (s_axis_h2c_areset) begin
            r_state <= ST_RECV;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_early     = 1'b0;
        w_missing   = 1'b0;
        case (r_state)
            ST_RECV: begin
                if (w_accept) begin
                    if (s_axis_h2c_tlast) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_FULL;
                        end else begin
                            w_early = 1'b1;
                        end
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        w_missing   = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && s_axis_h2c_tlast)
                    w_state_nxt = ST_RECV;
            end
            ST_FULL: begin
                if (r_data_valid && data_ready)
                    w_state_nxt = ST_RECV;
            end
            default: w_state_nxt = ST_RECV;
        endcase
    end

    always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
        if (s_axis_h2c_areset) begin
            r_asm      <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept && r_state == ST_RECV) begin
            r_asm <= w_asm_nxt;
            // Any frame end (good, early or missing tlast) restarts at beat 0.
            if (s_axis_h2c_tlast || r_beat_cnt == LAST_BEAT)
                r_beat_cnt <= '0;
            else
                r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
        if (s_axis_h2c_areset) begin
            r_data       <= '0;
            r_data_seq   <= '0;
            r_data_valid <= 1'b0;
            r_exp_seq    <= '0;
        end else begin
            if (w_done) begin
                r_data       <= w_asm_nxt[DATA_WIDTH+SEQ_WIDTH-1:SEQ_WIDTH];
                r_data_seq   <= w_seq_in;
                r_data_valid <= 1'b1;
                r_exp_seq    <= w_seq_in + 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
        if (s_axis_h2c_areset) begin
            r_seq_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_seq_err   <= w_seq_mis;
            r_frame_err <= w_early || w_missing;
            if (w_err_evt && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign s_axis_h2c_tready = w_tready;
    assign data              = r_data;
    assign data_seq          = r_data_seq;
    assign data_valid        = r_data_valid;
    assign seq_err           = r_seq_err;
    assign frame_err         = r_frame_err;
    assign err_cnt           = r_err_cnt;
    assign ustate            = r_state;

endmodule

// File: tb/tb_axis_data_unpack.sv
// Scoreboard bench for axis_data_unpack: frames are queued when driven and
// compared when the DUT hands them to the core.
module tb_axis_data_unpack;

    localparam int DW = 4064;
    localparam int AW = 512;
    localparam int NB = 8;

    typedef struct {
        logic [7:0]    seq;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] tdata;
    logic [63:0]   tkeep;
    logic          tlast, tvalid, tready;
    logic [DW-1:0] data;
    logic [7:0]    data_seq;
    logic          data_valid, data_ready, seq_err, frame_err;
    logic [15:0]   err_cnt;
    logic [1:0]    ustate;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fails  = 0;
    int         n_seq_pulse, n_frame_pulse, n_delivered;
    int         m_seq_errs, m_frame_errs;
    logic [7:0] m_exp_seq;

    always #5 clk = ~clk;

    axis_data_unpack #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
        .s_axis_h2c_aclk   (clk),
        .s_axis_h2c_areset (rst),
        .s_axis_h2c_tdata  (tdata),
        .s_axis_h2c_tkeep  (tkeep),
        .s_axis_h2c_tlast  (tlast),
        .s_axis_h2c_tvalid (tvalid),
        .s_axis_h2c_tready (tready),
        .data              (data),
        .data_seq          (data_seq),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .seq_err           (seq_err),
        .frame_err         (frame_err),
        .err_cnt           (err_cnt),
        .ustate            (ustate)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int diff_words(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x;
        logic [31:0]   w;
        int            n;
        x = a ^ b;
        n = 0;
        for (int i = 0; i < DW; i += 32) begin
            w = 32'(x >> i);
            if (w != 32'd0) n++;
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] rand_payload();
        logic [DW-1:0] p;
        for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [DW-1:0] inc_payload();
        logic [DW-1:0] p;
        for (int i = 0; i < DW / 8; i++) p[i*8 +: 8] = 8'(i);
        return p;
    endfunction

    // Monitor: counts error pulses and scores each delivered frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (seq_err)   n_seq_pulse++;
                if (frame_err) n_frame_pulse++;
                if (data_valid && data_ready) begin
                    check("sb_nonempty", 64'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("data_seq", data_seq, e.seq);
                        check("data_words_diff", 64'(diff_words(data, e.d)), 0);
                    end
                    n_delivered++;
                end
            end
        end
    end

    task automatic send_beat(input logic [AW-1:0] d, input logic l);
        bit ok;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        ok     = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("tready_timeout", tready, 1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic send_beats(input logic [NB*AW-1:0] f, input int n, input int last_at);
        logic [AW-1:0] d;
        for (int k = 0; k < n; k++) begin
            if (k < NB) d = f[k*AW +: AW];
            else        d = {16{$urandom}};
            send_beat(d, k == last_at);
        end
    endtask

    task automatic send_good(input logic [7:0] seq, input logic [DW-1:0] pl);
        exp_t            e;
        logic [NB*AW-1:0] f;
        e.seq = seq;
        e.d   = pl;
        sb_q.push_back(e);
        if (seq != m_exp_seq) m_seq_errs++;
        m_exp_seq = seq + 8'd1;
        f = '0;
        f[7:0]    = seq;
        f[DW+7:8] = pl;
        send_beats(f, NB, NB - 1);
    endtask

    task automatic send_bad(input int n, input int last_at);
        logic [NB*AW-1:0] f;
        for (int i = 0; i < NB * AW / 32; i++) f[i*32 +: 32] = $urandom;
        m_frame_errs++;
        send_beats(f, n, last_at);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        sb_q.delete();
        m_exp_seq  = 8'd0;
        m_seq_errs = 0;
        m_frame_errs  = 0;
        n_seq_pulse   = 0;
        n_frame_pulse = 0;
        n_delivered   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic finish_group(input string name, input int exp_delivered);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        check({name, "_drain"}, 64'(sb_q.size()), 0);
        check({name, "_delivered"}, 64'(n_delivered), 64'(exp_delivered));
        check({name, "_seq_err_pulses"}, 64'(n_seq_pulse), 64'(m_seq_errs));
        check({name, "_frame_err_pulses"}, 64'(n_frame_pulse), 64'(m_frame_errs));
        check({name, "_err_cnt"}, err_cnt, 64'(m_seq_errs + m_frame_errs));
    endtask

    initial begin
        logic [DW-1:0] p1, p2;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '1; data_ready = 1'b0;
        n_seq_pulse = 0; n_frame_pulse = 0; n_delivered = 0;
        m_seq_errs = 0; m_frame_errs = 0; m_exp_seq = 8'd0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_tready", tready, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data_words", 64'(diff_words(data, '0)), 0);
        check("rst_data_seq", data_seq, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ustate", ustate, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_tready", tready, 1);

        // Single frame: valid the cycle after the last beat.
        do_reset();
        data_ready = 1'b1;
        send_good(8'h00, inc_payload());
        check("single_latency_valid", data_valid, 1);
        check("single_ustate_full", ustate, 2);
        check("single_tready_full", tready, 0);
        finish_group("single", 1);

        // Back-pressure: output held, tready low, then both frames flow.
        do_reset();
        data_ready = 1'b0;
        p1 = rand_payload();
        p2 = rand_payload();
        send_good(8'h00, p1);
        fork
            send_good(8'h01, p2);
            begin
                repeat (20) begin
                    @(negedge clk);
                    check("bp_tready", tready, 0);
                    check("bp_valid", data_valid, 1);
                    check("bp_data_words_diff", 64'(diff_words(data, p1)), 0);
                end
                @(posedge clk); #1;
                data_ready = 1'b1;
            end
        join
        finish_group("backpressure", 2);

        // Sequence gap: 0x00, 0x02, 0x03.
        do_reset();
        send_good(8'h00, rand_payload());
        send_good(8'h02, rand_payload());
        send_good(8'h03, rand_payload());
        finish_group("seq_gap", 3);
        check("seq_gap_err_cnt_one", err_cnt, 1);

        // Wrap-around: 0xFF through 0xFE.
        do_reset();
        for (int i = 0; i < 256; i++) send_good(8'(8'hFF + i), rand_payload());
        finish_group("wrap", 256);
        check("wrap_err_cnt_one", err_cnt, 1);

        // Early tlast, then missing tlast, each followed by a good frame.
        do_reset();
        send_bad(4, 3);
        send_good(8'h00, rand_payload());
        send_bad(11, 10);
        send_good(8'h01, rand_payload());
        finish_group("framing", 2);
        check("framing_ustate_recv", ustate, 0);

        // Reset in the middle of a frame.
        do_reset();
        send_bad(4, -1);
        m_frame_errs = 0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", tready, 0);
        check("midrst_ustate", ustate, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_good(8'h00, rand_payload());
        finish_group("midreset", 1);
        check("midrst_err_cnt_zero", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
